// File: rtl/rmdr_ser.sv
// Word-to-serial front end for an external bit-serial mod-3 checker.
// Serializes each accepted word MSB-first, then samples the checker's verdict.
module rmdr_ser #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_clr,
  output logic         ser_bit,
  output logic         ser_last,
  input  logic         chk_in,
  output logic         res_valid,
  output logic         res_div3,
  output logic         busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic          res_div3_q, res_div3_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_div3_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_div3_q  <= res_div3_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    res_div3_d  = res_div3_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          state_d = SHIFT;
          shift_d = din;
          cnt_d   = CNT_MAX;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[W-2:0], 1'b0};
        // Leave on the LSB cycle rather than wrapping the counter.
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SAMPLE: begin
        res_div3_d  = chk_in;
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_q == IDLE);
    ser_clr   = (state_q == IDLE);
    busy      = (state_q != IDLE);
    ser_bit   = (state_q == SHIFT) ? shift_q[W-1] : 1'b0;
    ser_last  = (state_q == SHIFT) && (cnt_q == '0);
  end

  assign res_valid = res_valid_q;
  assign res_div3  = res_div3_q;

endmodule

// File: tb/tb_rmdr_ser.sv
// Directed bench for rmdr_ser with a behavioural serial mod-3 checker in the loop.
module tb_rmdr_ser;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         ser_clr;
  logic         ser_bit;
  logic         ser_last;
  logic         chk_in;
  logic         res_valid;
  logic         res_div3;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rmdr_ser #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_clr   (ser_clr),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
    .chk_in    (chk_in),
    .res_valid (res_valid),
    .res_div3  (res_div3),
    .busy      (busy)
  );

  // Serial mod-3 checker: remainder r -> (2r + bit) mod 3, cleared by ser_clr.
  logic [1:0] rem_q;
  always_ff @(posedge clk) begin
    if (ser_clr) rem_q <= 2'd0;
    else begin
      case ({rem_q, ser_bit})
        3'b000:  rem_q <= 2'd0;
        3'b001:  rem_q <= 2'd1;
        3'b010:  rem_q <= 2'd2;
        3'b011:  rem_q <= 2'd0;
        3'b100:  rem_q <= 2'd1;
        3'b101:  rem_q <= 2'd2;
        default: rem_q <= 2'd0;
      endcase
    end
  end
  assign chk_in = (rem_q == 2'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present d in the current (IDLE) cycle, follow it through SHIFT/SAMPLE and
  // return in the res_valid cycle (W+2 cycles later), still IDLE.
  task automatic run_word(input logic [W-1:0] d, input logic exp_div3, input string tag);
    logic [W-1:0] dv;
    dv = d;
    if (din_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s accept_ready got=%b exp=1", tag, din_ready);
    end
    n_checks++;
    din = d; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 1; i <= int'(W); i++) begin
      if (ser_bit !== dv[W-i] || ser_last !== (i == int'(W)) || busy !== 1'b1 ||
          din_ready !== 1'b0 || ser_clr !== 1'b0) begin
        n_fail++;
        $display("FAIL %s shift_c%0d got bit=%b last=%b busy=%b rdy=%b clr=%b exp bit=%b last=%b busy=1 rdy=0 clr=0",
                 tag, i, ser_bit, ser_last, busy, din_ready, ser_clr, dv[W-i], (i == int'(W)));
      end
      n_checks++;
      tick();
    end
    if (busy !== 1'b1 || ser_bit !== 1'b0 || ser_last !== 1'b0 || res_valid !== 1'b0 || ser_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s sample got busy=%b bit=%b last=%b vld=%b clr=%b exp 1 0 0 0 0",
               tag, busy, ser_bit, ser_last, res_valid, ser_clr);
    end
    n_checks++;
    tick();
    if (res_valid !== 1'b1 || res_div3 !== exp_div3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result got vld=%b div3=%b busy=%b exp vld=1 div3=%b busy=0",
               tag, res_valid, res_div3, busy, exp_div3);
    end
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    if (din_ready !== 1'b1 || ser_clr !== 1'b1 || ser_bit !== 1'b0 || ser_last !== 1'b0 ||
        busy !== 1'b0 || res_valid !== 1'b0 || res_div3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b clr=%b bit=%b last=%b busy=%b vld=%b div3=%b exp 1 1 0 0 0 0 0",
               din_ready, ser_clr, ser_bit, ser_last, busy, res_valid, res_div3);
    end
    n_checks++;
    tick(); tick();
    if (busy !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold got busy=%b rdy=%b exp 0 1", busy, din_ready);
    end
    n_checks++;
  endtask

  task automatic test_basic();
    run_word(8'h0C, 1'b1, "w0C");
    tick();
    if (res_valid !== 1'b0 || res_div3 !== 1'b1) begin
      n_fail++; $display("FAIL pulse_hold got vld=%b div3=%b exp 0 1", res_valid, res_div3);
    end
    n_checks++;
    run_word(8'h0D, 1'b0, "w0D");
    tick();
    run_word(8'hFF, 1'b1, "wFF");
    tick();
    run_word(8'h00, 1'b1, "w00");
    tick(); tick();
    if (res_div3 !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle got vld=%b div3=%b exp 0 1", res_valid, res_div3);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [4];
    logic         exps  [4];
    words = '{8'd3, 8'd4, 8'd5, 8'd6};
    exps  = '{1'b1, 1'b0, 1'b0, 1'b1};
    din = words[0]; din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = words[k];
      if (din_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready%0d got=%b exp=1", k, din_ready);
      end
      n_checks++;
      tick();
      din = words[(k + 1) % 4];
      for (int c = 1; c <= 9; c++) begin
        if (din_ready !== 1'b0 || res_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_busy%0d_c%0d got rdy=%b vld=%b exp 0 0", k, c, din_ready, res_valid);
        end
        n_checks++;
        tick();
      end
      if (res_valid !== 1'b1 || res_div3 !== exps[k]) begin
        n_fail++; $display("FAIL b2b_res%0d got vld=%b div3=%b exp 1 %b", k, res_valid, res_div3, exps[k]);
      end
      n_checks++;
    end
    din_valid = 1'b0;
    tick();
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_tail got busy=%b exp 0", busy);
    end
    n_checks++;
  endtask

  task automatic test_ignore_during_shift();
    din = 8'h0D; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick();
    din = 8'h0C; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    if (res_valid !== 1'b1 || res_div3 !== 1'b0) begin
      n_fail++; $display("FAIL ignore_res got vld=%b div3=%b exp 1 0", res_valid, res_div3);
    end
    n_checks++;
    tick();
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL ignore_noextra got busy=%b vld=%b exp 0 0", busy, res_valid);
    end
    n_checks++;
  endtask

  task automatic test_reset_abort();
    din = 8'h0C; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (busy !== 1'b0 || ser_clr !== 1'b1 || din_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got busy=%b clr=%b rdy=%b vld=%b exp 0 1 1 0",
                         busy, ser_clr, din_ready, res_valid);
    end
    n_checks++;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (res_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_nopulse_c%0d got vld=%b exp 0", c, res_valid);
      end
      n_checks++;
    end
    run_word(8'h09, 1'b1, "w09");
    tick();
    rst = 1'b1; din = 8'h0D; din_valid = 1'b1;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    if (busy !== 1'b0 || res_div3 !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_priority got busy=%b div3=%b rdy=%b exp 0 0 1", busy, res_div3, din_ready);
    end
    n_checks++;
  endtask

  task automatic test_sweep();
    logic [W-1:0] order [256];
    logic [W-1:0] tmp;
    int unsigned  j;
    for (int i = 0; i < 256; i++) order[i] = W'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      run_word(order[i], ((int'(order[i]) % 3) == 0), "sweep");
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_during_shift();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
